fake_netlist_bist_driver: RTL
=============================

# fake_netlist_bist_driver

Built-in self-test driver for the 5-input/1-output fake netlist blocks. It generates pseudo-random patterns on the netlist inputs (n_0..n_4) with an LFSR and applies each pattern for a programmable settle time. It then compacts the netlist response (n_9) into a MISR signature and compares the final signature against a golden value. It sits on the input/output boundary of a fake netlist instance and exercises it from the other end.

## Interface
- PAT_W, 5, pattern width (netlist input count)
- PAT_TAPS, 5'h14, Fibonacci LFSR tap mask (x^5+x^3+1)
- SIG_W, 8, signature width
- SIG_POLY, 8'h1D, MISR feedback polynomial (x^8+x^4+x^3+x^2+1)
- CNT_W, 8, pattern-count width
- SETTLE, 1, cycles each pattern is held before capture (≥1)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin run; sampled only in IDLE
- seed  in  PAT_W  initial LFSR value; 0 is replaced by 1
- num_patterns  in  CNT_W  number of patterns to apply
- golden_sig  in  SIG_W  expected signature
- pattern_o  out  PAT_W  drives netlist inputs {n_4..n_0}; equals the LFSR register
- resp_i  in  1  netlist output n_9
- busy  out  1  high in APPLY/CAPTURE
- done  out  1  one-cycle pulse at end of run
- signature  out  SIG_W  MISR contents; held after run
- pass  out  1  signature==golden_sig; registered on entry to DONE; held until next start

## Operation
- States: IDLE, APPLY, CAPTURE, DONE.
- IDLE & start:
  - lfsr←(seed==0 ? 1 : seed), misr←0, cnt←0, settle←0, pass←0.
  - Go to APPLY, or to DONE if num_patterns==0.
- APPLY: settle increments each cycle; after SETTLE cycles go to CAPTURE.
- CAPTURE (one cycle):
  - misr←{misr[SIG_W-2:0],0} ^ (misr[SIG_W-1] ? SIG_POLY : 0) ^ resp_i (into bit 0).
  - lfsr←{lfsr[PAT_W-2:0], ^(lfsr & PAT_TAPS)}; cnt++; settle←0.
  - If cnt==num_patterns-1, go to DONE; else go to APPLY.
- DONE: done=1 for one cycle, pass←(misr==golden_sig), then IDLE.
- LFSR sequence from seed 0x01: 0x01, 0x02, 0x04, 0x09, 0x12, …; period 31.
- start, seed, num_patterns and golden_sig are only sampled in IDLE. Changing them while busy has no effect, and start while busy is ignored.
- start asserted in the DONE cycle is ignored; it is accepted in the following IDLE cycle.
- num_patterns is unsigned; 255 applies 255 patterns, and the LFSR wraps through its period.

## Timing
- Reset values: pattern_o=0, busy=0, done=0, signature=0, pass=0, state=IDLE.
- Reset asserted mid-run aborts immediately to these values. No done pulse is generated.
- start sampled at edge k:
  - pattern_o=seed' from cycle k+1.
  - The first capture happens at the end of cycle k+SETTLE+1.
  - Each pattern occupies SETTLE+1 cycles.
- done is high in cycle k+N·(SETTLE+1)+1; busy falls in that same cycle.
- For num_patterns==0, done is high in cycle k+1 with signature=0.
- resp_i is sampled only at the CAPTURE edge. The netlist path must settle within SETTLE cycles of pattern_o changing.
- signature updates only at CAPTURE edges and is stable otherwise. pass is valid from the done cycle onward.

## Test plan
- Sequence check: seed=0x01, N=5, SETTLE=1, resp_i=0. Required: pattern_o steps 0x01→0x02→0x04→0x09→0x12, with a change every 2 cycles; signature=0x00; done in cycle k+11.
- MISR arithmetic: seed=0x01, N=9, resp_i=1, golden_sig=0xE2. Required: signature sequence 01,03,07,0F,1F,3F,7F,FF,E2; pass=1. Repeat with golden 0xE3: pass=0.
- Edge cases: seed=0 gives first pattern 0x01. N=0 gives done at k+1 with signature 0x00 and busy never high. N=31 returns the LFSR to the seed value after the run.
- Start handling: start pulsed while busy causes no restart and no change in timing. start held high continuously gives back-to-back runs, each with its own done pulse, and a gap of one IDLE cycle between runs.
- Reset mid-run: rst_n low during APPLY of pattern 3 → all outputs reset asynchronously, no done pulse. A fresh start afterwards reproduces the first-run signature.
- Live netlist: connect a fake netlist instance with seed=0x05, N=20, SETTLE=2. The signature must match the reference model, and pass=1 with that value as golden_sig.

Source files
------------

// File: rtl/fake_netlist_bist_driver_if.sv
// Control and netlist-boundary signals of the fake netlist BIST driver.
// The master side is the system/netlist; the slave side is the driver.
interface fake_netlist_bist_driver_if #(
  parameter int PAT_W = 5,
  parameter int SIG_W = 8,
  parameter int CNT_W = 8
);
  logic             start;
  logic [PAT_W-1:0] seed;
  logic [CNT_W-1:0] num_patterns;
  logic [SIG_W-1:0] golden_sig;
  logic [PAT_W-1:0] pattern_o;
  logic             resp_i;
  logic             busy;
  logic             done;
  logic [SIG_W-1:0] signature;
  logic             pass;

  modport master (
    output start, seed, num_patterns, golden_sig, resp_i,
    input  pattern_o, busy, done, signature, pass
  );

  modport slave (
    input  start, seed, num_patterns, golden_sig, resp_i,
    output pattern_o, busy, done, signature, pass
  );
endinterface

// File: rtl/fake_netlist_bist_driver.sv
// LFSR pattern generator + MISR response compactor for fake netlist BIST.
//   state   | meaning
//   IDLE    | waiting for start; run parameters latched on start
//   APPLY   | pattern held on netlist inputs for SETTLE cycles
//   CAPTURE | response folded into MISR, LFSR advanced
//   DONE    | one-cycle done pulse, pass valid
module fake_netlist_bist_driver #(
  parameter int               PAT_W    = 5,
  parameter logic [PAT_W-1:0] PAT_TAPS = 5'h14,
  parameter int               SIG_W    = 8,
  parameter logic [SIG_W-1:0] SIG_POLY = 8'h1D,
  parameter int               CNT_W    = 8,
  parameter int               SETTLE   = 1
) (
  input  logic clk,
  input  logic rst_n,
  fake_netlist_bist_driver_if.slave bus
);
  localparam int STL_W = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_APPLY, S_CAPTURE, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [PAT_W-1:0] lfsr, lfsr_nxt;
  logic [SIG_W-1:0] misr, misr_nxt;
  logic [CNT_W-1:0] cnt, num_q;
  logic [SIG_W-1:0] golden_q;
  logic [STL_W-1:0] settle;
  logic             pass_q;
  logic             last_pat;

  assign lfsr_nxt = {lfsr[PAT_W-2:0], ^(lfsr & PAT_TAPS)};
  assign misr_nxt = {misr[SIG_W-2:0], 1'b0}
                  ^ (misr[SIG_W-1] ? SIG_POLY : '0)
                  ^ {{(SIG_W-1){1'b0}}, bus.resp_i};
  assign last_pat = (cnt == num_q - CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (bus.start) state_nxt = (bus.num_patterns == '0) ? S_DONE : S_APPLY;
      S_APPLY:   if (settle == STL_W'(SETTLE - 1)) state_nxt = S_CAPTURE;
      S_CAPTURE: state_nxt = last_pat ? S_DONE : S_APPLY;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state == S_APPLY) || (state == S_CAPTURE);
    bus.done = (state == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr     <= '0;
      misr     <= '0;
      cnt      <= '0;
      settle   <= '0;
      pass_q   <= 1'b0;
      num_q    <= '0;
      golden_q <= '0;
    end else begin
      case (state)
        S_IDLE: if (bus.start) begin
          lfsr     <= (bus.seed == '0) ? PAT_W'(1) : bus.seed;
          misr     <= '0;
          cnt      <= '0;
          settle   <= '0;
          num_q    <= bus.num_patterns;
          golden_q <= bus.golden_sig;
          // an empty run enters DONE straight away with a zero signature
          pass_q   <= (bus.num_patterns == '0) && (bus.golden_sig == '0);
        end
        S_APPLY: settle <= settle + 1'b1;
        S_CAPTURE: begin
          misr   <= misr_nxt;
          lfsr   <= lfsr_nxt;
          cnt    <= cnt + 1'b1;
          settle <= '0;
          if (last_pat) pass_q <= (misr_nxt == golden_q);
        end
        default: ;
      endcase
    end
  end

  assign bus.pattern_o = lfsr;
  assign bus.signature = misr;
  assign bus.pass      = pass_q;
endmodule
